// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, arbiter state encoding and helpers
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;

  localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
  localparam logic [2:0] ST_LOAD_ENC    = 3'd1;
  localparam logic [2:0] ST_LAUNCH_ENC  = 3'd2;
  localparam logic [2:0] ST_WAIT_HI_ENC = 3'd3;
  localparam logic [2:0] ST_WAIT_LO_ENC = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_LOAD    = ST_LOAD_ENC,
    ST_LAUNCH  = ST_LAUNCH_ENC,
    ST_WAIT_HI = ST_WAIT_HI_ENC,
    ST_WAIT_LO = ST_WAIT_LO_ENC
  } arb_state_e;

  // Index width that never collapses to zero bits for a single requester.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - round-robin pick: rotate, priority-encode, rotate back
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  always_comb begin
    dbl = {req, req} >> ptr;
    rot = dbl[N_REQ-1:0];
    off = '0;
    // Descending scan so the lowest rotated position (closest to ptr) wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = IDX_W'(i);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W + 1)'(N_REQ)) begin
      sum = sum - (IDX_W + 1)'(N_REQ);
    end
    idx = sum[IDX_W-1:0];
    any = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-locked round-robin arbiter feeding one UART transmitter
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int STALL_TO  = 4096
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              s_tvalid,
  input  logic [N_REQ*DATA_BITS-1:0]    s_tdata,
  input  logic [N_REQ-1:0]              s_tlast,
  output logic [N_REQ-1:0]              s_tready,
  output logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_start,
  input  logic                          tx_busy,
  output logic [clog2_min1(N_REQ)-1:0]  grant_id,
  output logic                          grant_vld,
  output logic                          stall_err
);

  localparam int IDX_W = clog2_min1(N_REQ);
  localparam int CNT_W = clog2_min1(STALL_TO);

  arb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 grant_vld_q, grant_vld_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 last_q, last_d;
  logic                 tx_start_q, tx_start_d;
  logic                 stall_err_q, stall_err_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 own_valid;
  logic                 own_last;
  logic [DATA_BITS-1:0] own_data;
  logic [IDX_W-1:0]     owner_inc;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req (s_tvalid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Only the owner's lane is ever looked at, so other sources cannot steer s_tready.
  assign own_valid = s_tvalid[owner_q];
  assign own_last  = s_tlast[owner_q];
  assign own_data  = s_tdata[owner_q*DATA_BITS +: DATA_BITS];
  assign owner_inc = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    s_tready = '0;
    if (state_q == ST_LOAD && own_valid) begin
      s_tready[owner_q] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    grant_vld_d = grant_vld_q;
    tx_data_d   = tx_data_q;
    last_d      = last_q;
    tx_start_d  = 1'b0;
    stall_err_d = 1'b0;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          owner_d     = pick_idx;
          grant_vld_d = 1'b1;
          stall_cnt_d = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (own_valid) begin
          tx_data_d   = own_data;
          last_d      = own_last;
          stall_cnt_d = '0;
          state_d     = ST_LAUNCH;
        end else if (stall_cnt_q == CNT_W'(STALL_TO - 1)) begin
          stall_err_d = 1'b1;
          grant_vld_d = 1'b0;
          rr_ptr_d    = owner_inc;
          stall_cnt_d = '0;
          state_d     = ST_IDLE;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      ST_LAUNCH: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (tx_busy) begin
          state_d = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (!tx_busy) begin
          if (last_q) begin
            grant_vld_d = 1'b0;
            rr_ptr_d    = owner_inc;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      grant_vld_q <= 1'b0;
      tx_data_q   <= '0;
      last_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      stall_err_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      grant_vld_q <= grant_vld_d;
      tx_data_q   <= tx_data_d;
      last_q      <= last_d;
      tx_start_q  <= tx_start_d;
      stall_err_q <= stall_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign grant_id  = owner_q;
  assign grant_vld = grant_vld_q;
  assign stall_err = stall_err_q;

endmodule
